// File: rtl/mem_hold_responder_if.sv
// mem_hold_responder_if: control-unit stall handshake plus data-memory req/ack port
interface mem_hold_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hold;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              unhold;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [7:0]        err_cnt;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  hold, mem_read, mem_write, addr, wdata, mem_ack, mem_rdata,
    output unhold, rdata, err, err_cnt, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output hold, mem_read, mem_write, addr, wdata, mem_ack, mem_rdata,
    input  unhold, rdata, err, err_cnt, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_hold_responder.sv
// mem_hold_responder: runs one captured load/store per rising hold edge against a req/ack memory, then pulses unhold
module mem_hold_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_hold_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  state_t      state;
  logic        hold_q;
  logic [15:0] wait_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_q        <= 1'b0;
      wait_cnt      <= '0;
      bus.unhold    <= 1'b0;
      bus.rdata     <= '0;
      bus.err       <= 1'b0;
      bus.err_cnt   <= '0;
      bus.busy      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      hold_q <= bus.hold;
      case (state)
        IDLE: if (bus.hold && !hold_q) begin
          bus.busy <= 1'b1;
          if (bus.mem_read ^ bus.mem_write) begin
            bus.mem_addr  <= ADDR_W'(bus.addr);
            bus.mem_wdata <= DATA_W'(bus.wdata);
            bus.mem_we    <= bus.mem_write;
            bus.mem_req   <= 1'b1;
            wait_cnt      <= '0;
            state         <= REQ;
          end else
            state <= bus.mem_read ? ERR : DONE;
        end
        REQ: if (bus.mem_ack) begin
          bus.mem_req <= 1'b0;
          bus.unhold  <= 1'b1;
          if (!bus.mem_we) bus.rdata <= DATA_W'(bus.mem_rdata);
          state <= DONE;
        end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
          bus.mem_req <= 1'b0;
          bus.unhold  <= 1'b1;
          bus.err     <= 1'b1;
          bus.err_cnt <= bus.err_cnt + 8'(bus.err_cnt != 8'hff);
          state       <= ERR;
        end else
          wait_cnt <= wait_cnt + 16'd1;
        // entered from REQ the pulse is already up; from IDLE it is raised one cycle later
        default: if (bus.unhold) begin
          bus.unhold <= 1'b0;
          bus.err    <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end else begin
          bus.unhold <= 1'b1;
          bus.err    <= state == ERR;
          if (state == ERR) bus.err_cnt <= bus.err_cnt + 8'(bus.err_cnt != 8'hff);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_hold_responder.sv
// tb_mem_hold_responder: directed and random stimulus checked every cycle against an event-scheduling model
module tb_mem_hold_responder;
  localparam int TIMEOUT = 4;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  mem_hold_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_hold_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int cmp = 0;
  int mism = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // memory responder: acks after a programmed number of request cycles, or randomly
  logic        rand_ack = 1'b0;
  int          ack_after = 0;
  int          rcnt = 0;
  logic [31:0] rd_val = '0;
  always @(negedge clk) begin
    if (rand_ack) begin
      bus.mem_ack   = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
    end else begin
      rcnt          = bus.mem_req ? rcnt + 1 : 0;
      bus.mem_ack   = bus.mem_req && (rcnt == ack_after);
      bus.mem_rdata = rd_val;
    end
  end
  // model: schedules when the request ends, when unhold pulses and when the block is free again
  longint      n = 0;
  logic        m_act = 1'b0, m_perr = 1'b0, m_prev = 1'b0, m_we = 1'b0;
  int          m_age = 0;
  longint      m_pulse_at = -1, m_free_at = 0;
  logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0;
  logic [7:0]  m_cnt = '0;
  int          n_unhold = 0, n_reqs = 0;
  logic        prev_req = 1'b0;
  always @(posedge clk) begin
    n++;
    if (!rst_n) begin
      m_act = 0; m_free_at = n; m_pulse_at = -1; m_prev = 0;
      m_rdata = 0; m_cnt = 0; m_addr = 0; m_wdata = 0; m_we = 0;
    end else begin
      if (m_act) begin
        if (bus.mem_ack) begin
          m_act = 0; m_pulse_at = n; m_perr = 0; m_free_at = n + 1;
          if (!m_we) m_rdata = bus.mem_rdata;
        end else if (m_age == TIMEOUT - 1) begin
          m_act = 0; m_pulse_at = n; m_perr = 1; m_free_at = n + 1;
        end else m_age++;
      end else if (m_free_at < n && bus.hold && !m_prev) begin
        if (bus.mem_read ^ bus.mem_write) begin
          m_act = 1; m_age = 0; m_addr = bus.addr; m_wdata = bus.wdata; m_we = bus.mem_write;
        end else begin
          m_pulse_at = n + 1; m_perr = bus.mem_read; m_free_at = n + 2;
        end
      end
      if (m_pulse_at == n && m_perr && m_cnt != 8'hff) m_cnt++;
      m_prev = bus.hold;
    end
    #1;
    chk("unhold", {31'd0, bus.unhold}, {31'd0, m_pulse_at == n});
    chk("err", {31'd0, bus.err}, {31'd0, m_pulse_at == n && m_perr});
    chk("busy", {31'd0, bus.busy}, {31'd0, m_act || m_free_at > n});
    chk("mem_req", {31'd0, bus.mem_req}, {31'd0, m_act});
    chk("rdata", bus.rdata, m_rdata);
    chk("err_cnt", {24'd0, bus.err_cnt}, {24'd0, m_cnt});
    if (m_act || !rst_n) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("mem_we", {31'd0, bus.mem_we}, {31'd0, m_we});
    end
    if (bus.unhold) n_unhold++;
    if (bus.mem_req && !prev_req) n_reqs++;
    prev_req = bus.mem_req;
  end
  task automatic drop();
    bus.hold = 0; bus.mem_read = 0; bus.mem_write = 0;
    @(negedge clk);
  endtask
  task automatic wait_unhold();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.unhold) return;
    end
    cmp++; mism++;
    $display("FAIL wait_unhold: no unhold within 40 cycles");
  endtask
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input int ack_n);
    ack_after = ack_n; bus.mem_read = rd; bus.mem_write = wr; bus.addr = a; bus.wdata = d; bus.hold = 1;
    wait_unhold();
    drop();
  endtask
  int u0, r0, sel;
  initial begin
    rst_n = 0; bus.hold = 0; bus.mem_read = 0; bus.mem_write = 0; bus.addr = 0; bus.wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_unhold", {31'd0, bus.unhold}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_err_cnt", {24'd0, bus.err_cnt}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    rd_val = 32'hDEADBEEF; ack_after = 3; bus.addr = 32'h40; bus.mem_read = 1; bus.hold = 1;
    @(negedge clk);
    chk("t1_req", {31'd0, bus.mem_req}, 1);
    chk("t1_addr", bus.mem_addr, 32'h40);
    chk("t1_we", {31'd0, bus.mem_we}, 0);
    repeat (2) @(negedge clk);
    chk("t1_req3", {31'd0, bus.mem_req}, 1);
    @(negedge clk);
    chk("t1_unhold", {31'd0, bus.unhold}, 1);
    chk("t1_req_off", {31'd0, bus.mem_req}, 0);
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_single", {31'd0, bus.unhold}, 0);
    drop();
    ack_after = 1; rd_val = 32'h0BAD0BAD; bus.addr = 32'h10; bus.wdata = 32'h12345678; bus.mem_write = 1; bus.hold = 1;
    @(negedge clk);
    chk("t2_we", {31'd0, bus.mem_we}, 1);
    chk("t2_wdata", bus.mem_wdata, 32'h12345678);
    @(negedge clk);
    chk("t2_unhold", {31'd0, bus.unhold}, 1);
    chk("t2_rdata", bus.rdata, 32'hDEADBEEF);
    drop();
    ack_after = 0; bus.addr = 32'h80; bus.mem_read = 1; bus.hold = 1;
    repeat (4) @(negedge clk);
    chk("t3_req4", {31'd0, bus.mem_req}, 1);
    @(negedge clk);
    chk("t3_req_off", {31'd0, bus.mem_req}, 0);
    chk("t3_err", {31'd0, bus.err}, 1);
    chk("t3_err_cnt", {24'd0, bus.err_cnt}, 1);
    drop();
    bus.mem_read = 1; bus.mem_write = 1; bus.hold = 1;
    @(negedge clk);
    chk("t4_ill_noreq", {31'd0, bus.mem_req}, 0);
    @(negedge clk);
    chk("t4_ill_err", {31'd0, bus.err}, 1);
    chk("t4_ill_cnt", {24'd0, bus.err_cnt}, 2);
    drop();
    bus.hold = 1;
    @(negedge clk);
    chk("t4_stall_wait", {31'd0, bus.unhold}, 0);
    @(negedge clk);
    chk("t4_stall_unhold", {31'd0, bus.unhold}, 1);
    chk("t4_stall_err", {31'd0, bus.err}, 0);
    drop();
    repeat (256) access(1, 0, 32'h44, 0, 0);
    chk("t3_sat", {24'd0, bus.err_cnt}, 255);
    access(1, 1, 0, 0, 0);
    chk("t4_sat_hold", {24'd0, bus.err_cnt}, 255);
    u0 = n_unhold; r0 = n_reqs;
    rd_val = 32'hCAFEF00D; ack_after = 2; bus.addr = 32'h20; bus.mem_read = 1; bus.hold = 1;
    repeat (12) @(negedge clk);
    chk("t5_one_unhold", n_unhold - u0, 1);
    chk("t5_one_req", n_reqs - r0, 1);
    chk("t5_rdata", bus.rdata, 32'hCAFEF00D);
    bus.hold = 0;
    @(negedge clk);
    bus.hold = 1;
    wait_unhold();
    chk("t5_second_req", n_reqs - r0, 2);
    drop();
    ack_after = 0; bus.addr = 32'h99; bus.mem_read = 1; bus.hold = 1;
    repeat (2) @(negedge clk);
    ack_after = 2; rst_n = 0;
    #1;
    chk("t6_req_drop", {31'd0, bus.mem_req}, 0);
    chk("t6_busy_drop", {31'd0, bus.busy}, 0);
    chk("t6_rdata0", bus.rdata, 0);
    chk("t6_addr0", bus.mem_addr, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t6_restart", {31'd0, bus.mem_req}, 1);
    wait_unhold();
    drop();
    rand_ack = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.hold = !bus.hold;
        if (bus.hold) begin
          sel = $urandom_range(0, 9);
          bus.mem_read  = (sel < 4) || (sel == 7);
          bus.mem_write = (sel >= 4) && (sel <= 7);
          bus.addr      = $urandom;
          bus.wdata     = $urandom;
        end
      end
    end
    rst_n = 1;
    drop();
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule

// File: doc/mem_hold_responder.md
Name: mem_hold_responder

Overview:
- Responder side of the control unit's hold/unhold stall handshake.
- The control unit raises `hold` on a memory-class opcode. This block captures the access (read or write) and runs it against a slow data memory using a req/ack handshake. It then pulses `unhold` so the pipeline can resume.
- Sits between the control unit, the datapath address/data buses and the data memory port.

Parameters:
- ADDR_W, 32, width of address bus
- DATA_W, 32, width of data buses
- TIMEOUT, 255, maximum `mem_req` cycles without `mem_ack` before an error is reported (1..65535)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  stall request from control unit (level)
- mem_read  in  1  control: access is a load
- mem_write  in  1  control: access is a store
- addr  in  ADDR_W  access address from ALU result
- wdata  in  DATA_W  store data
- unhold  out  1  one-cycle completion pulse to control unit
- rdata  out  DATA_W  load result, held until the next load completes
- err  out  1  one-cycle pulse, coincident with `unhold`, on a failed access
- err_cnt  out  8  saturating count of errors
- busy  out  1  high in any state other than IDLE
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable (valid while `mem_req`)
- mem_addr  out  ADDR_W  memory address (valid while `mem_req`)
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory acknowledge (one cycle or level, sampled while `mem_req`)
- mem_rdata  in  DATA_W  memory read data, valid when `mem_ack`=1

Behaviour:
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - All outputs go to 0, including `rdata` and `err_cnt`; `mem_req` drops immediately.
  - Internal `hold_q` goes to 0.
- Arming: a request is accepted only on a rising edge of `hold` (`hold`=1 and `hold_q`=0 in IDLE). `hold_q` registers `hold` every cycle.
- If `hold` is high when reset is released, it counts as a rising edge and the access restarts. This is deliberate, to avoid a deadlock.
- States: IDLE, REQ, DONE, ERR.
- IDLE, on a rising edge of `hold`:
  - `mem_read`^`mem_write` = 1: latch `addr`/`wdata`/`mem_write` into `mem_addr`/`mem_wdata`/`mem_we`; `mem_req` goes to 1; clear the wait counter; go to REQ.
  - both 0: go to DONE, no memory access (pure stall).
  - both 1: go to ERR.
- REQ:
  - `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are held stable.
  - If `mem_ack`=1: `mem_req` goes to 0 on the same edge. If the access is a load, `rdata` takes `mem_rdata`. Go to DONE.
  - Else, if wait counter = TIMEOUT-1: `mem_req` goes to 0; go to ERR.
  - Else the wait counter increments.
  - If `mem_ack` and timeout coincide, `mem_ack` wins.
- DONE: `unhold`=1 for exactly one cycle, then go to IDLE.
- ERR:
  - `unhold`=1 and `err`=1 for one cycle.
  - `err_cnt` increments, saturating at 255.
  - `rdata` is unchanged.
  - Go to IDLE.
- Latency:
  - `hold` rise sampled at edge k gives `mem_req` high after edge k.
  - Ack sampled at edge m gives `unhold` high between edges m and m+1.
  - Minimum is 2 cycles from hold-edge sampling to the end of `unhold`.
  - Pure stall: `unhold` is high between edges k+1 and k+2.
- `mem_ack` outside REQ is ignored.
- `hold` falling during REQ does not abort: the access completes and `unhold` still pulses.
- A new `hold` rise during a non-IDLE state is not queued. `hold_q` tracks it, so only a rise seen in IDLE arms.
- `busy` = (state != IDLE), registered.

Test Plan:
1. Load, ack after 3 cycles: `addr`=0x40, `mem_read`=1, `hold` rises, `mem_rdata`=0xDEADBEEF with ack on the 3rd REQ cycle.
   - Required: `mem_req` high 3 cycles, `mem_we`=0, `mem_addr`=0x40, `rdata`=0xDEADBEEF, single `unhold` pulse, `err`=0.
2. Store with immediate ack: `addr`=0x10, `wdata`=0x12345678, `mem_write`=1, ack on the 1st REQ cycle.
   - Required: `mem_we`=1, `mem_wdata`=0x12345678, `unhold` 2 cycles after the hold edge, `rdata` unchanged.
3. Timeout: TIMEOUT=4, load, never ack.
   - Required: `mem_req` high exactly 4 cycles, then `unhold`=`err`=1 for one cycle, `err_cnt`=1.
   - Repeat 256 times: `err_cnt` saturates at 255.
4. Illegal and stall cases:
   - `hold` rise with `mem_read`=`mem_write`=1: no `mem_req`, `err` pulse, `err_cnt`+1.
   - `hold` rise with both 0: no `mem_req`, `unhold` 1 cycle later, `err`=0.
5. Level hold: keep `hold` high for 10 cycles after a completed load.
   - Required: exactly one access and one `unhold`. Dropping and re-raising `hold` starts a second access.
6. Reset mid-REQ: assert `rst_n`=0 during the 2nd REQ cycle, with `hold` kept high.
   - Required: `mem_req`/`busy` drop immediately; all outputs 0.
   - After release: a new access starts on the first edge.
